// File: rtl/game_ctrl_if.sv
// game_ctrl_if: bundles the per-frame game inputs and the controller status
// outputs of game_ctrl so the top level and the bench share one bus.
//
//   frame_tick  one-cycle pulse per video frame
//   start_btn   level start/restart request
//   frog_x/y    frog top-left position (pixels)
//   car_x       packed car left edges, slot s of lane l at l*CARS_PER_LANE+s
//   car_len     per-lane car length
//   log_x       packed log left edges, same packing as car_x
//   log_len     per-lane log length
//   state       FSM state code
//   lives       remaining lives
//   score       goals reached (saturating)
//   frog_reset  one-cycle pulse: move frog to its start position
//   ride_valid  frog stands on a log in lane ride_lane
//   ride_lane   lane of the log being ridden
//   overrun     sticky: a frame_tick arrived while a scan was still running
//
// Modports: slave = the controller, master = whatever drives the game inputs.
interface game_ctrl_if #(
    parameter int N_CAR_LANES   = 6,
    parameter int CARS_PER_LANE = 2,
    parameter int N_LOG_LANES   = 6,
    parameter int LOGS_PER_LANE = 2
);
    logic                                       frame_tick;
    logic                                       start_btn;
    logic [9:0]                                 frog_x;
    logic [9:0]                                 frog_y;
    logic [N_CAR_LANES*CARS_PER_LANE*10-1:0]    car_x;
    logic [N_CAR_LANES*10-1:0]                  car_len;
    logic [N_LOG_LANES*LOGS_PER_LANE*10-1:0]    log_x;
    logic [N_LOG_LANES*10-1:0]                  log_len;
    logic [2:0]                                 state;
    logic [3:0]                                 lives;
    logic [7:0]                                 score;
    logic                                       frog_reset;
    logic                                       ride_valid;
    logic [3:0]                                 ride_lane;
    logic                                       overrun;

    modport slave (
        input  frame_tick, start_btn, frog_x, frog_y,
               car_x, car_len, log_x, log_len,
        output state, lives, score, frog_reset, ride_valid, ride_lane, overrun
    );

    modport master (
        output frame_tick, start_btn, frog_x, frog_y,
               car_x, car_len, log_x, log_len,
        input  state, lives, score, frog_reset, ride_valid, ride_lane, overrun
    );
endinterface

// File: rtl/game_ctrl.sv
// game_ctrl: frogger-style game controller. Once per frame it snapshots the
// frog position, tests it against every car and log (one object per clock),
// then resolves death, goal or survival and manages lives/score/respawn.
//
//   clk      game clock, all state on the rising edge
//   reset_n  asynchronous active-low reset
//   bus      game_ctrl_if.slave: frame/start inputs, frog and object
//            positions in; state/lives/score/frog_reset/ride/overrun out
module game_ctrl #(
    parameter int N_CAR_LANES   = 6,
    parameter int CARS_PER_LANE = 2,
    parameter int N_LOG_LANES   = 6,
    parameter int LOGS_PER_LANE = 2,
    parameter int BLOCK         = 32,
    parameter int CAR_Y0        = 256,
    parameter int LOG_Y0        = 32,
    parameter int X_MIN         = 96,
    parameter int X_MAX         = 576,
    parameter int LIVES         = 3,
    parameter int DEATH_FRAMES  = 30
) (
    input  logic            clk,
    input  logic            reset_n,
    game_ctrl_if.slave      bus
);
    localparam int NC    = N_CAR_LANES * CARS_PER_LANE;
    localparam int NL    = N_LOG_LANES * LOGS_PER_LANE;
    localparam int TOTAL = NC + NL;
    localparam int IDX_W = $clog2(TOTAL + 1);
    localparam int DC_W  = $clog2(DEATH_FRAMES + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PLAY     = 3'd1,
        SCAN     = 3'd2,
        DYING    = 3'd3,
        GAMEOVER = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         lives_q, lives_d;
    logic [7:0]         score_q, score_d;
    logic               frog_reset_q, frog_reset_d;
    logic               ride_valid_q, ride_valid_d;
    logic [3:0]         ride_lane_q, ride_lane_d;
    logic               overrun_q, overrun_d;
    logic [IDX_W-1:0]   index_q, index_d;
    logic               hit_q, hit_d;
    logic               on_log_q, on_log_d;
    logic [3:0]         log_lane_q, log_lane_d;
    logic [9:0]         fx_q, fx_d;
    logic [9:0]         fy_q, fy_d;
    logic [DC_W-1:0]    death_cnt_q, death_cnt_d;

    // Object currently addressed by the scan index.
    logic [9:0]         obj_x;
    logic [9:0]         obj_len;
    logic [10:0]        obj_y;
    logic               obj_is_log;
    logic [3:0]         obj_lane;

    logic [10:0]        fx11, fy11;
    logic               overlap;
    logic               water, off_screen, goal, death;

    // Mux out one object per cycle: cars occupy indices 0..NC-1, logs follow.
    always_comb begin
        obj_x      = '0;
        obj_len    = '0;
        obj_y      = '0;
        obj_is_log = 1'b0;
        obj_lane   = '0;
        for (int i = 0; i < NC; i++) begin
            if (index_q == IDX_W'(i)) begin
                obj_x   = bus.car_x[i*10 +: 10];
                obj_len = bus.car_len[(i/CARS_PER_LANE)*10 +: 10];
                obj_y   = 11'(CAR_Y0 + (i/CARS_PER_LANE)*BLOCK);
            end
        end
        for (int j = 0; j < NL; j++) begin
            if (index_q == IDX_W'(NC + j)) begin
                obj_x      = bus.log_x[j*10 +: 10];
                obj_len    = bus.log_len[(j/LOGS_PER_LANE)*10 +: 10];
                obj_y      = 11'(LOG_Y0 + (j/LOGS_PER_LANE)*BLOCK);
                obj_is_log = 1'b1;
                obj_lane   = 4'(j/LOGS_PER_LANE);
            end
        end
    end

    // Geometry is evaluated at 11 bits so x+len and y+BLOCK never wrap.
    always_comb begin
        fx11       = {1'b0, fx_q};
        fy11       = {1'b0, fy_q};
        overlap    = (fx11 < ({1'b0, obj_x} + {1'b0, obj_len})) &&
                     ((fx11 + 11'(BLOCK)) > {1'b0, obj_x}) &&
                     (fy11 < (obj_y + 11'(BLOCK))) &&
                     ((fy11 + 11'(BLOCK)) > obj_y);
        water      = (fy11 >= 11'(LOG_Y0)) &&
                     (fy11 < 11'(LOG_Y0 + N_LOG_LANES*BLOCK)) && !on_log_q;
        off_screen = ((fx11 + 11'(BLOCK)) <= 11'(X_MIN)) || (fx11 >= 11'(X_MAX));
        goal       = fy11 < 11'(LOG_Y0);
        death      = hit_q || water || off_screen;
    end

    always_comb begin
        state_d      = state_q;
        lives_d      = lives_q;
        score_d      = score_q;
        frog_reset_d = 1'b0;
        ride_valid_d = ride_valid_q;
        ride_lane_d  = ride_lane_q;
        overrun_d    = overrun_q;
        index_d      = index_q;
        hit_d        = hit_q;
        on_log_d     = on_log_q;
        log_lane_d   = log_lane_q;
        fx_d         = fx_q;
        fy_d         = fy_q;
        death_cnt_d  = death_cnt_q;

        case (state_q)
            IDLE: begin
                lives_d      = 4'(LIVES);
                score_d      = '0;
                ride_valid_d = 1'b0;
                ride_lane_d  = '0;
                if (bus.start_btn) begin
                    state_d      = PLAY;
                    frog_reset_d = 1'b1;
                end
            end

            PLAY: begin
                if (bus.frame_tick) begin
                    state_d    = SCAN;
                    fx_d       = bus.frog_x;
                    fy_d       = bus.frog_y;
                    hit_d      = 1'b0;
                    on_log_d   = 1'b0;
                    log_lane_d = '0;
                    index_d    = '0;
                end
            end

            SCAN: begin
                if (bus.frame_tick) begin
                    overrun_d = 1'b1;
                end
                if (index_q == IDX_W'(TOTAL)) begin
                    // Every object tested: resolve the frame.
                    index_d = '0;
                    if (death) begin
                        ride_valid_d = 1'b0;
                        ride_lane_d  = '0;
                        if (lives_q <= 4'd1) begin
                            lives_d = '0;
                            state_d = GAMEOVER;
                        end else begin
                            lives_d     = lives_q - 4'd1;
                            state_d     = DYING;
                            death_cnt_d = '0;
                        end
                    end else if (goal) begin
                        score_d      = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                        frog_reset_d = 1'b1;
                        ride_valid_d = 1'b0;
                        ride_lane_d  = '0;
                        state_d      = PLAY;
                    end else begin
                        ride_valid_d = on_log_q;
                        ride_lane_d  = log_lane_q;
                        state_d      = PLAY;
                    end
                end else begin
                    index_d = index_q + IDX_W'(1);
                    if (overlap) begin
                        if (!obj_is_log) begin
                            hit_d = 1'b1;
                        end else if (!on_log_q) begin
                            // First matching log is the lowest index; keep it.
                            on_log_d   = 1'b1;
                            log_lane_d = obj_lane;
                        end
                    end
                end
            end

            DYING: begin
                ride_valid_d = 1'b0;
                ride_lane_d  = '0;
                if (bus.frame_tick) begin
                    if (death_cnt_q == DC_W'(DEATH_FRAMES - 1)) begin
                        state_d      = PLAY;
                        frog_reset_d = 1'b1;
                        death_cnt_d  = '0;
                    end else begin
                        death_cnt_d = death_cnt_q + DC_W'(1);
                    end
                end
            end

            GAMEOVER: begin
                lives_d      = '0;
                ride_valid_d = 1'b0;
                ride_lane_d  = '0;
                if (bus.start_btn) begin
                    state_d      = PLAY;
                    lives_d      = 4'(LIVES);
                    score_d      = '0;
                    frog_reset_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            lives_q      <= 4'(LIVES);
            score_q      <= '0;
            frog_reset_q <= 1'b0;
            ride_valid_q <= 1'b0;
            ride_lane_q  <= '0;
            overrun_q    <= 1'b0;
            index_q      <= '0;
            hit_q        <= 1'b0;
            on_log_q     <= 1'b0;
            log_lane_q   <= '0;
            fx_q         <= '0;
            fy_q         <= '0;
            death_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            lives_q      <= lives_d;
            score_q      <= score_d;
            frog_reset_q <= frog_reset_d;
            ride_valid_q <= ride_valid_d;
            ride_lane_q  <= ride_lane_d;
            overrun_q    <= overrun_d;
            index_q      <= index_d;
            hit_q        <= hit_d;
            on_log_q     <= on_log_d;
            log_lane_q   <= log_lane_d;
            fx_q         <= fx_d;
            fy_q         <= fy_d;
            death_cnt_q  <= death_cnt_d;
        end
    end

    assign bus.state      = state_q;
    assign bus.lives      = lives_q;
    assign bus.score      = score_q;
    assign bus.frog_reset = frog_reset_q;
    assign bus.ride_valid = ride_valid_q;
    assign bus.ride_lane  = ride_lane_q;
    assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: self-checking bench for game_ctrl. Each scenario task pushes
// the outcome it expects onto a scoreboard queue, drives the frame, then pops
// and compares when the controller has produced its result.
module tb_game_ctrl;
    localparam int NCL = 6;
    localparam int CPL = 2;
    localparam int NLL = 6;
    localparam int LPL = 2;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PLAY     = 3'd1;
    localparam logic [2:0] S_SCAN     = 3'd2;
    localparam logic [2:0] S_DYING    = 3'd3;
    localparam logic [2:0] S_GAMEOVER = 3'd4;

    typedef struct packed {
        logic [2:0] state;
        logic [3:0] lives;
        logic [7:0] score;
        logic       frog_reset;
        logic       ride_valid;
        logic [3:0] ride_lane;
    } outcome_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    game_ctrl_if #(
        .N_CAR_LANES(NCL), .CARS_PER_LANE(CPL),
        .N_LOG_LANES(NLL), .LOGS_PER_LANE(LPL)
    ) gif ();

    game_ctrl #(
        .N_CAR_LANES(NCL), .CARS_PER_LANE(CPL),
        .N_LOG_LANES(NLL), .LOGS_PER_LANE(LPL)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (gif)
    );

    outcome_t exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic outcome_t mk(logic [2:0] st, logic [3:0] lv, logic [7:0] sc,
                                    logic fr, logic rv, logic [3:0] rl);
        return {st, lv, sc, fr, rv, rl};
    endfunction

    function automatic outcome_t sample();
        return {gif.state, gif.lives, gif.score, gif.frog_reset, gif.ride_valid, gif.ride_lane};
    endfunction

    task automatic set_car(int lane, int slot, int x, int len);
        gif.car_x[(lane*CPL+slot)*10 +: 10] = 10'(x);
        gif.car_len[lane*10 +: 10]          = 10'(len);
    endtask

    task automatic set_log(int lane, int slot, int x, int len);
        gif.log_x[(lane*LPL+slot)*10 +: 10] = 10'(x);
        gif.log_len[lane*10 +: 10]          = 10'(len);
    endtask

    // Every object parked at x=0, length 32: never touches a frog at x>=64.
    task automatic clear_field();
        for (int l = 0; l < NCL; l++)
            for (int s = 0; s < CPL; s++) set_car(l, s, 0, 32);
        for (int l = 0; l < NLL; l++)
            for (int s = 0; s < LPL; s++) set_log(l, s, 0, 32);
    endtask

    task automatic set_frog(int x, int y);
        gif.frog_x = 10'(x);
        gif.frog_y = 10'(y);
    endtask

    // lat counts clock edges after the edge that sampled frame_tick.
    task automatic do_frame(output int lat, output outcome_t obs);
        gif.frame_tick = 1'b1;
        step();
        gif.frame_tick = 1'b0;
        lat = 0;
        while (gif.state == S_SCAN && lat < 60) begin
            step();
            lat++;
        end
        obs = sample();
    endtask

    task automatic pulse_tick();
        gif.frame_tick = 1'b1;
        step();
        gif.frame_tick = 1'b0;
        step();
    endtask

    task automatic press_start();
        gif.start_btn = 1'b1;
        step();
        gif.start_btn = 1'b0;
    endtask

    task automatic test_reset();
        outcome_t e, o;
        exp_q.push_back(mk(S_IDLE, 4'd3, 8'd0, 1'b0, 1'b0, 4'd0));
        o = sample();
        e = exp_q.pop_front();
        n_tests++;
        if (o !== e) begin n_fail++; $display("[TB] FAIL reset_state: got %h, expected %h", o, e); end
        n_tests++;
        if (gif.overrun !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_overrun: got %b, expected 0", gif.overrun); end
    endtask

    task automatic test_start();
        outcome_t e, o;
        exp_q.push_back(mk(S_PLAY, 4'd3, 8'd0, 1'b1, 1'b0, 4'd0));
        exp_q.push_back(mk(S_PLAY, 4'd3, 8'd0, 1'b0, 1'b0, 4'd0));
        press_start();
        o = sample();
        e = exp_q.pop_front();
        n_tests++;
        if (o !== e) begin n_fail++; $display("[TB] FAIL start_pulse: got %h, expected %h", o, e); end
        step();
        o = sample();
        e = exp_q.pop_front();
        n_tests++;
        if (o !== e) begin n_fail++; $display("[TB] FAIL start_single_pulse: got %h, expected %h", o, e); end
    endtask

    task automatic test_dying_recovery(logic [3:0] lv, logic [7:0] sc);
        outcome_t e, o;
        exp_q.push_back(mk(S_DYING, lv, sc, 1'b0, 1'b0, 4'd0));
        exp_q.push_back(mk(S_PLAY, lv, sc, 1'b1, 1'b0, 4'd0));
        gif.start_btn = 1'b1;
        repeat (29) pulse_tick();
        gif.start_btn = 1'b0;
        o = sample();
        e = exp_q.pop_front();
        n_tests++;
        if (o !== e) begin n_fail++; $display("[TB] FAIL dying_29_ticks: got %h, expected %h", o, e); end
        gif.frame_tick = 1'b1;
        step();
        gif.frame_tick = 1'b0;
        o = sample();
        e = exp_q.pop_front();
        n_tests++;
        if (o !== e) begin n_fail++; $display("[TB] FAIL dying_respawn: got %h, expected %h", o, e); end
        step();
    endtask

    task automatic test_car_hit();
        outcome_t e, o;
        int lat;
        clear_field();
        set_car(0, 0, 300, 64);
        set_frog(320, 256);
        exp_q.push_back(mk(S_DYING, 4'd2, 8'd0, 1'b0, 1'b0, 4'd0));
        do_frame(lat, o);
        n_tests++;
        if (lat !== 25) begin n_fail++; $display("[TB] FAIL car_hit_latency: got %0d cycles, expected 25", lat); end
        e = exp_q.pop_front();
        n_tests++;
        if (o !== e) begin n_fail++; $display("[TB] FAIL car_hit: got %h, expected %h", o, e); end
        test_dying_recovery(4'd2, 8'd0);
        clear_field();
    endtask

    task automatic test_log_ride();
        outcome_t e, o;
        int lat;
        clear_field();
        set_log(1, 1, 180, 96);
        set_frog(200, 64);
        exp_q.push_back(mk(S_PLAY, 4'd2, 8'd0, 1'b0, 1'b1, 4'd1));
        do_frame(lat, o);
        e = exp_q.pop_front();
        n_tests++;
        if (o !== e) begin n_fail++; $display("[TB] FAIL log_ride_lane1: got %h, expected %h", o, e); end

        // Frog straddles lanes 0 and 1; lane 0 holds the lower-index log.
        set_log(0, 0, 190, 96);
        set_frog(200, 48);
        exp_q.push_back(mk(S_PLAY, 4'd2, 8'd0, 1'b0, 1'b1, 4'd0));
        do_frame(lat, o);
        e = exp_q.pop_front();
        n_tests++;
        if (o !== e) begin n_fail++; $display("[TB] FAIL log_lowest_index: got %h, expected %h", o, e); end

        set_log(0, 0, 0, 32);
        set_log(1, 1, 300, 96);
        set_frog(200, 64);
        exp_q.push_back(mk(S_DYING, 4'd1, 8'd0, 1'b0, 1'b0, 4'd0));
        do_frame(lat, o);
        e = exp_q.pop_front();
        n_tests++;
        if (o !== e) begin n_fail++; $display("[TB] FAIL water_death: got %h, expected %h", o, e); end
        test_dying_recovery(4'd1, 8'd0);
        clear_field();
    endtask

    task automatic test_goal_and_offscreen();
        outcome_t e, o;
        int lat;
        clear_field();
        set_frog(320, 0);
        exp_q.push_back(mk(S_PLAY, 4'd1, 8'd1, 1'b1, 1'b0, 4'd0));
        do_frame(lat, o);
        e = exp_q.pop_front();
        n_tests++;
        if (o !== e) begin n_fail++; $display("[TB] FAIL goal_score: got %h, expected %h", o, e); end

        // x=65 keeps one pixel inside the left edge; x=64 is just off.
        set_frog(65, 448);
        exp_q.push_back(mk(S_PLAY, 4'd1, 8'd1, 1'b0, 1'b0, 4'd0));
        do_frame(lat, o);
        e = exp_q.pop_front();
        n_tests++;
        if (o !== e) begin n_fail++; $display("[TB] FAIL edge_inside: got %h, expected %h", o, e); end

        set_frog(64, 448);
        exp_q.push_back(mk(S_GAMEOVER, 4'd0, 8'd1, 1'b0, 1'b0, 4'd0));
        do_frame(lat, o);
        e = exp_q.pop_front();
        n_tests++;
        if (o !== e) begin n_fail++; $display("[TB] FAIL offscreen_gameover: got %h, expected %h", o, e); end

        exp_q.push_back(mk(S_GAMEOVER, 4'd0, 8'd1, 1'b0, 1'b0, 4'd0));
        pulse_tick();
        o = sample();
        e = exp_q.pop_front();
        n_tests++;
        if (o !== e) begin n_fail++; $display("[TB] FAIL gameover_hold: got %h, expected %h", o, e); end

        exp_q.push_back(mk(S_PLAY, 4'd3, 8'd0, 1'b1, 1'b0, 4'd0));
        press_start();
        o = sample();
        e = exp_q.pop_front();
        n_tests++;
        if (o !== e) begin n_fail++; $display("[TB] FAIL gameover_restart: got %h, expected %h", o, e); end

        exp_q.push_back(mk(S_PLAY, 4'd3, 8'd0, 1'b0, 1'b0, 4'd0));
        step();
        press_start();
        step();
        o = sample();
        e = exp_q.pop_front();
        n_tests++;
        if (o !== e) begin n_fail++; $display("[TB] FAIL start_ignored_play: got %h, expected %h", o, e); end
    endtask

    task automatic test_overrun();
        outcome_t e, o;
        clear_field();
        set_car(0, 0, 300, 64);
        set_frog(320, 256);
        exp_q.push_back(mk(S_DYING, 4'd2, 8'd0, 1'b0, 1'b0, 4'd0));
        gif.frame_tick = 1'b1;
        step();
        gif.frame_tick = 1'b0;
        repeat (4) step();
        gif.frame_tick = 1'b1;
        step();
        gif.frame_tick = 1'b0;
        n_tests++;
        if (gif.overrun !== 1'b1) begin n_fail++; $display("[TB] FAIL overrun_set: got %b, expected 1", gif.overrun); end
        repeat (19) step();
        n_tests++;
        if (gif.state !== S_SCAN) begin n_fail++; $display("[TB] FAIL overrun_still_scan: got %0d, expected %0d", gif.state, S_SCAN); end
        step();
        o = sample();
        e = exp_q.pop_front();
        n_tests++;
        if (o !== e) begin n_fail++; $display("[TB] FAIL overrun_outcome: got %h, expected %h", o, e); end
        step();
        n_tests++;
        if (gif.overrun !== 1'b1) begin n_fail++; $display("[TB] FAIL overrun_sticky: got %b, expected 1", gif.overrun); end
        clear_field();
    endtask

    task automatic test_reset_dying();
        outcome_t e, o;
        exp_q.push_back(mk(S_IDLE, 4'd3, 8'd0, 1'b0, 1'b0, 4'd0));
        reset_n = 1'b0;
        #2;
        o = sample();
        e = exp_q.pop_front();
        n_tests++;
        if (o !== e) begin n_fail++; $display("[TB] FAIL reset_mid_dying: got %h, expected %h", o, e); end
        n_tests++;
        if (gif.overrun !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_clears_overrun: got %b, expected 0", gif.overrun); end
        #1;
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_reset_mid_scan();
        outcome_t e, o;
        int lat;
        press_start();
        step();
        clear_field();
        set_car(0, 0, 300, 64);
        set_frog(320, 256);
        exp_q.push_back(mk(S_DYING, 4'd2, 8'd0, 1'b0, 1'b0, 4'd0));
        do_frame(lat, o);
        e = exp_q.pop_front();
        n_tests++;
        if (o !== e) begin n_fail++; $display("[TB] FAIL rescan_car_hit: got %h, expected %h", o, e); end
        test_dying_recovery(4'd2, 8'd0);

        clear_field();
        set_log(1, 1, 180, 96);
        set_frog(200, 64);
        exp_q.push_back(mk(S_PLAY, 4'd2, 8'd0, 1'b0, 1'b1, 4'd1));
        do_frame(lat, o);
        e = exp_q.pop_front();
        n_tests++;
        if (o !== e) begin n_fail++; $display("[TB] FAIL rescan_ride: got %h, expected %h", o, e); end

        exp_q.push_back(mk(S_IDLE, 4'd3, 8'd0, 1'b0, 1'b0, 4'd0));
        gif.frame_tick = 1'b1;
        step();
        gif.frame_tick = 1'b0;
        repeat (10) step();
        reset_n = 1'b0;
        #2;
        o = sample();
        e = exp_q.pop_front();
        n_tests++;
        if (o !== e) begin n_fail++; $display("[TB] FAIL reset_mid_scan: got %h, expected %h", o, e); end
        #1;
        reset_n = 1'b1;
        step();
        clear_field();
    endtask

    // Goal frames issued the cycle after each outcome; score must stop at 255.
    task automatic test_back_to_back_goals();
        outcome_t e, o;
        int lat;
        press_start();
        step();
        set_frog(320, 0);
        for (int k = 1; k <= 256; k++) begin
            exp_q.push_back(mk(S_PLAY, 4'd3, 8'((k > 255) ? 255 : k), 1'b1, 1'b0, 4'd0));
            do_frame(lat, o);
            e = exp_q.pop_front();
            n_tests++;
            if (o !== e) begin n_fail++; $display("[TB] FAIL goal_b2b_%0d: got %h, expected %h", k, o, e); end
        end
    endtask

    initial begin
        reset_n        = 1'b0;
        gif.frame_tick = 1'b0;
        gif.start_btn  = 1'b0;
        gif.frog_x     = '0;
        gif.frog_y     = '0;
        gif.car_x      = '0;
        gif.car_len    = '0;
        gif.log_x      = '0;
        gif.log_len    = '0;
        clear_field();
        repeat (3) step();
        test_reset();
        reset_n = 1'b1;
        step();
        test_start();
        test_car_hit();
        test_log_ride();
        test_goal_and_offscreen();
        test_overrun();
        test_reset_dying();
        test_reset_mid_scan();
        test_back_to_back_goals();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
